// File: rtl/id_decode_stage.sv
// RV32I decode stage: combinational decode of the fetched word into a single
// output pipeline register with valid/ready backpressure, flush and illegal flag.
module id_decode_stage (
  input  logic        clk,
  input  logic        res_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  output logic        one_src,
  output logic [4:0]  rd_addr,
  output logic        reg_write,
  output logic [31:0] imm,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic        funct7b5,
  output logic [31:0] pc_out,
  output logic        illegal
);

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;

  logic        use_rs1;
  logic        use_rs2;
  logic        writes_rd;
  logic        dec_illegal;
  logic [31:0] dec_imm;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [4:0]  dec_rd;
  logic        dec_reg_write;

  logic        valid_q;
  logic [4:0]  rs1_q;
  logic [4:0]  rs2_q;
  logic        one_src_q;
  logic [4:0]  rd_q;
  logic        reg_write_q;
  logic [31:0] imm_q;
  logic [6:0]  opcode_q;
  logic [2:0]  funct3_q;
  logic        funct7b5_q;
  logic [31:0] pc_q;
  logic        illegal_q;

  logic        load;
  logic        valid_d;

  // Every supported opcode ends in 2'b11, so the opcode match also covers instr[1:0].
  always_comb begin
    use_rs1     = 1'b0;
    use_rs2     = 1'b0;
    writes_rd   = 1'b0;
    dec_illegal = 1'b0;
    dec_imm     = 32'h0;
    case (in_instr[6:0])
      OpLui, OpAuipc: begin
        writes_rd = 1'b1;
        dec_imm   = {in_instr[31:12], 12'h000};
      end
      OpJal: begin
        writes_rd = 1'b1;
        dec_imm   = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                     in_instr[30:21], 1'b0};
      end
      OpJalr, OpLoad, OpImm: begin
        use_rs1   = 1'b1;
        writes_rd = 1'b1;
        dec_imm   = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      OpBranch: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        dec_imm = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                   in_instr[11:8], 1'b0};
      end
      OpStore: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        dec_imm = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      OpReg: begin
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
        writes_rd = 1'b1;
      end
      default: begin
        dec_illegal = 1'b1;
      end
    endcase
  end

  always_comb begin
    dec_rd        = in_instr[11:7];
    dec_rs1       = use_rs1 ? in_instr[19:15] : 5'd0;
    dec_rs2       = use_rs2 ? in_instr[24:20] : 5'd0;
    dec_reg_write = writes_rd & (dec_rd != 5'd0);
  end

  assign in_ready = ~valid_q | out_ready;
  assign load     = in_valid & in_ready & ~flush;

  always_comb begin
    valid_d = valid_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      valid_q     <= 1'b0;
      rs1_q       <= 5'd0;
      rs2_q       <= 5'd0;
      one_src_q   <= 1'b0;
      rd_q        <= 5'd0;
      reg_write_q <= 1'b0;
      imm_q       <= 32'h0;
      opcode_q    <= 7'd0;
      funct3_q    <= 3'd0;
      funct7b5_q  <= 1'b0;
      pc_q        <= 32'h0;
      illegal_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (load) begin
        rs1_q       <= dec_rs1;
        rs2_q       <= dec_rs2;
        one_src_q   <= ~use_rs2;
        rd_q        <= dec_rd;
        reg_write_q <= dec_reg_write;
        imm_q       <= dec_imm;
        opcode_q    <= in_instr[6:0];
        funct3_q    <= in_instr[14:12];
        funct7b5_q  <= in_instr[30];
        pc_q        <= in_pc;
        illegal_q   <= dec_illegal;
      end
    end
  end

  assign out_valid = valid_q;
  assign rs1_addr  = rs1_q;
  assign rs2_addr  = rs2_q;
  assign one_src   = one_src_q;
  assign rd_addr   = rd_q;
  assign reg_write = reg_write_q;
  assign imm       = imm_q;
  assign opcode    = opcode_q;
  assign funct3    = funct3_q;
  assign funct7b5  = funct7b5_q;
  assign pc_out    = pc_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_id_decode_stage.sv
// Scoreboard bench for id_decode_stage: a driver pushes reference decodes on accept,
// a negedge monitor compares the held output against the queue head.
module tb_id_decode_stage;

  logic        clk = 1'b0;
  logic        res_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = 32'h0;
  logic [31:0] in_pc = 32'h0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        one_src;
  logic [4:0]  rd_addr;
  logic        reg_write;
  logic [31:0] imm;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic [31:0] pc_out;
  logic        illegal;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        one_src;
    logic [4:0]  rd;
    logic        reg_write;
    logic [31:0] imm;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [31:0] pc;
    logic        illegal;
  } dec_t;

  dec_t q[$];
  int   errors = 0;
  int   checks = 0;
  bit   held = 1'b0;
  bit   running = 1'b0;

  id_decode_stage dut (
    .clk       (clk),
    .res_n     (res_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .one_src   (one_src),
    .rd_addr   (rd_addr),
    .reg_write (reg_write),
    .imm       (imm),
    .opcode    (opcode),
    .funct3    (funct3),
    .funct7b5  (funct7b5),
    .pc_out    (pc_out),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference decode built from the instruction-format tables.
  function automatic dec_t model(input logic [31:0] ins, input logic [31:0] pc);
    dec_t d;
    string fmt;
    logic [12:0] b;
    logic [20:0] j;
    logic [11:0] s;
    logic [11:0] i12;
    int sx;
    bit r1, r2, wr;
    case (ins[6:0])
      7'b0110111, 7'b0010111: begin fmt = "U"; r1 = 0; r2 = 0; wr = 1; end
      7'b1101111:             begin fmt = "J"; r1 = 0; r2 = 0; wr = 1; end
      7'b1100111, 7'b0000011, 7'b0010011: begin fmt = "I"; r1 = 1; r2 = 0; wr = 1; end
      7'b1100011:             begin fmt = "B"; r1 = 1; r2 = 1; wr = 0; end
      7'b0100011:             begin fmt = "S"; r1 = 1; r2 = 1; wr = 0; end
      7'b0110011:             begin fmt = "R"; r1 = 1; r2 = 1; wr = 1; end
      default:                begin fmt = "X"; r1 = 0; r2 = 0; wr = 0; end
    endcase
    i12 = ins[31:20];
    s   = {ins[31:25], ins[11:7]};
    b   = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    j   = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    sx  = 0;
    if (fmt == "I") sx = $signed(i12);
    if (fmt == "S") sx = $signed(s);
    if (fmt == "B") sx = $signed(b);
    if (fmt == "J") sx = $signed(j);
    if (fmt == "U") sx = int'(ins & 32'hFFFF_F000);
    d.rs1       = r1 ? ins[19:15] : 5'd0;
    d.rs2       = r2 ? ins[24:20] : 5'd0;
    d.one_src   = !r2;
    d.rd        = ins[11:7];
    d.reg_write = wr && (ins[11:7] != 0);
    d.imm       = sx;
    d.opcode    = ins[6:0];
    d.funct3    = ins[14:12];
    d.funct7b5  = ins[30];
    d.pc        = pc;
    d.illegal   = (fmt == "X");
    return d;
  endfunction

  // One cycle of stimulus: drive after the edge, account for the handshake before the next.
  task automatic cycle(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                       input bit fl, input bit rdy);
    bit accept;
    @(posedge clk);
    #1;
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    flush     = fl;
    out_ready = rdy;
    #6;
    chk("in_ready", 128'(in_ready), 128'(!held || rdy));
    accept = v && (!held || rdy) && !fl;
    if (accept) q.push_back(model(ins, pc));
    if (fl) held = 0;
    else if (accept) held = 1;
    else if (rdy) held = 0;
  endtask

  task automatic async_reset();
    @(posedge clk);
    #3;
    res_n = 1'b0;
    in_valid = 1'b0;
    flush = 1'b0;
    #1;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_reg_write", 128'(reg_write), 128'(0));
    chk("rst_imm", 128'(imm), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    q.delete();
    held = 0;
    @(posedge clk);
    #3;
    res_n = 1'b1;
  endtask

  initial begin : monitor
    dec_t got;
    forever begin
      @(negedge clk);
      if (running && res_n) begin
        chk("held_count", 128'(out_valid), 128'(q.size()));
        if (out_valid && q.size() != 0) begin
          got = '{rs1_addr, rs2_addr, one_src, rd_addr, reg_write, imm, opcode, funct3,
                  funct7b5, pc_out, illegal};
          chk($sformatf("decode pc=%08h", q[0].pc), 128'(got), 128'(q[0]));
          if (out_ready || flush) void'(q.pop_front());
        end
      end
    end
  end

  initial begin : driver
    logic [31:0] r;
    logic [31:0] ins;
    logic [6:0]  opc;
    logic [6:0]  opcs [9] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                              7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};
    #2;
    chk("init_out_valid", 128'(out_valid), 128'(0));
    chk("init_in_ready", 128'(in_ready), 128'(1));
    chk("init_imm", 128'(imm), 128'(0));
    chk("init_pc_out", 128'(pc_out), 128'(0));
    #10;
    res_n = 1'b1;
    running = 1'b1;

    cycle(1, 32'h0050_0093, 32'h100, 0, 1);
    cycle(1, 32'h0020_81B3, 32'h104, 0, 1);
    cycle(1, 32'h0020_A423, 32'h108, 0, 1);
    cycle(1, 32'hFE20_8EE3, 32'h10C, 0, 1);
    cycle(1, 32'h1234_52B7, 32'h110, 0, 1);
    cycle(0, 32'h0, 32'h0, 0, 1);

    // Backpressure: held instruction stays stable, then swaps with the waiting one.
    cycle(1, 32'h0070_0113, 32'h200, 0, 1);
    repeat (3) cycle(1, 32'h0031_01B3, 32'h204, 0, 0);
    cycle(1, 32'h0031_01B3, 32'h204, 0, 1);
    cycle(0, 32'h0, 32'h0, 0, 1);

    // Flush drops both the held and incoming instruction.
    cycle(1, 32'h0010_0213, 32'h300, 0, 1);
    cycle(1, 32'h0020_0293, 32'h304, 1, 0);
    cycle(0, 32'h0, 32'h0, 0, 0);
    cycle(1, 32'h0000_0000, 32'h308, 0, 1);
    cycle(0, 32'h0, 32'h0, 0, 1);

    // Asynchronous reset in the middle of a stall.
    cycle(1, 32'hFFF0_0313, 32'h400, 0, 1);
    cycle(1, 32'h0050_0393, 32'h404, 0, 0);
    async_reset();
    cycle(1, 32'h0050_0093, 32'h408, 0, 1);
    cycle(0, 32'h0, 32'h0, 0, 1);

    for (int n = 0; n < 2000; n++) begin
      r = $urandom();
      if ($urandom_range(0, 9) == 9) opc = 7'($urandom());
      else opc = opcs[$urandom_range(0, 8)];
      ins = {r[31:7], opc};
      cycle($urandom_range(0, 3) != 0, ins, $urandom(), $urandom_range(0, 19) == 0,
            $urandom_range(0, 2) != 0);
    end
    repeat (3) cycle(0, 32'h0, 32'h0, 0, 1);
    chk("final_drain", 128'(q.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
